sccb_responder: RTL

//   SCCB slave (responder) for simulation of the camera side and for on-chip loopback of our SCCB masters.

---
 rtl/sccb_pkg.sv | 27 ++
 rtl/sccb_responder_if.sv | 10 +
 rtl/sccb_line_sync.sv | 31 +++
 rtl/sccb_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_NA,
        ST_WAIT_STOP
    } state_t;

    localparam logic       SCCB_WRITE         = 1'b0;
    localparam logic       SCCB_READ          = 1'b1;
    localparam logic [7:0] SCCB_DEFAULT_WR_ID = 8'h42;
    localparam logic [7:0] SCCB_DEFAULT_RD_ID = 8'h43;

    // The R/W bit (bit 0) never takes part in address matching.
    function automatic logic id_match(input logic [7:0] rx, input logic [7:0] id);
        return ((rx ^ id) & 8'hFE) == 8'h00;
    endfunction

endpackage

// File: rtl/sccb_responder_if.sv
// Two-wire SCCB bus as seen by the responder: clock and pad-level data in, open-drain pull-down out.
interface sccb_responder_if;
    // sio_d_in is the resolved pad level; sio_d_oe=1 pulls the line low, 0 releases it.
    logic sio_c;
    logic sio_d_in;
    logic sio_d_oe;

    modport master (output sio_c, output sio_d_in, input sio_d_oe);
    modport slave  (input sio_c, input sio_d_in, output sio_d_oe);
endinterface

// File: rtl/sccb_line_sync.sv
// Synchroniser plus edge detector for one asynchronous SCCB line.
module sccb_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Reset to the idle-bus level so releasing reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            dly_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB responder: decodes ID/sub-address/data, issues register write strobes and serves reads.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] SLAVE_ID    = SCCB_DEFAULT_WR_ID,
    parameter int         SYNC_STAGES = 2,
    parameter bit         ACK_ENABLE  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    sccb_responder_if.slave     bus,
    output logic                wr_en,
    output logic [7:0]          wr_addr,
    output logic [7:0]          wr_data,
    output logic [7:0]          rd_addr,
    input  logic [7:0]          rd_data,
    output logic                busy,
    output state_t              dbg_state
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    sccb_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(rst_n), .line(bus.sio_c),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    sccb_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(rst_n), .line(bus.sio_d_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] sub_q, sub_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic       ack_hi_q, ack_hi_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       wr_en_q, wr_en_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;

    assign rx_byte = {shreg_q, sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            sub_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ack_hi_q  <= 1'b0;
            rw_q      <= SCCB_WRITE;
            oe_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            sub_q     <= sub_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ack_hi_q  <= ack_hi_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        sub_d     = sub_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ack_hi_d  = ack_hi_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        wr_en_d   = 1'b0;
        busy_d    = busy_q;

        if (start_det) begin
            state_d   = ST_ID;
            bit_cnt_d = '0;
            shreg_d   = '0;
            oe_d      = 1'b0;
            ack_hi_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            oe_d     = 1'b0;
            ack_hi_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            ack_hi_d  = 1'b0;
                            case (state_q)
                                ST_ID: begin
                                    if (!id_match(rx_byte, SLAVE_ID)) begin
                                        state_d = ST_WAIT_STOP;
                                    end else begin
                                        rw_d    = rx_byte[0];
                                        state_d = ST_ID_ACK;
                                    end
                                end
                                ST_SUB: begin
                                    sub_d   = rx_byte;
                                    state_d = ST_SUB_ACK;
                                end
                                default: begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = sub_q;
                                    wr_data_d = rx_byte;
                                    state_d   = ST_WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First fall opens the ack slot, second fall closes it.
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_hi_q) begin
                            oe_d     = ACK_ENABLE;
                            ack_hi_d = 1'b1;
                        end else begin
                            oe_d     = 1'b0;
                            ack_hi_d = 1'b0;
                            shreg_d  = '0;
                            case (state_q)
                                ST_ID_ACK: begin
                                    if (rw_q == SCCB_READ) begin
                                        tx_d      = {rd_data[6:0], 1'b0};
                                        oe_d      = ~rd_data[7];
                                        bit_cnt_d = 4'd1;
                                        state_d   = ST_RDATA;
                                    end else begin
                                        state_d = ST_SUB;
                                    end
                                end
                                ST_SUB_ACK: state_d = ST_WDATA;
                                default:    state_d = ST_WAIT_STOP;
                            endcase
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RD_NA;
                        end else begin
                            oe_d      = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_NA: begin
                    if (scl_rise) state_d = ST_WAIT_STOP;
                end
                default: ;
            endcase
        end
    end

    assign bus.sio_d_oe = oe_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_addr      = sub_q;
    assign busy         = busy_q;
    assign dbg_state    = state_q;

endmodule
